// File: rtl/cycle_controller.sv
// Machine-cycle sequencer for the control unit: steps FETCH/EXEC against the
// timing generator's phase bus and decodes the datapath strobes for each phase.
module cycle_controller #(
    parameter int OPW  = 4,
    parameter int IC_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      phase,
    input  logic            clk_s0,
    input  logic            clk_s1,
    input  logic            step,
    input  logic [OPW-1:0]  opcode,
    input  logic            zero,
    output logic            E,
    output logic            running,
    output logic            halted,
    output logic            addr_sel,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            ir_ld,
    output logic            pc_inc,
    output logic            pc_ld,
    output logic            acc_ld,
    output logic [1:0]      alu_op,
    output logic [IC_W-1:0] instr_count,
    output logic            phase_err,
    output logic            illegal_op
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_SUB  = 2'd2;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] op;
    logic       op_hi_zero;
    logic       op_legal;
    logic       op_is_hlt;
    logic       perr;
    logic       launch;
    logic       retire;

    // Only the low nibble is decoded; any set bit above it makes the opcode illegal.
    assign op         = opcode[3:0];
    assign op_hi_zero = ((opcode >> 4) == '0);
    assign op_is_hlt  = op_hi_zero && (op == OP_HLT);

    always_comb begin
        case (op)
            OP_NOP, OP_LDA, OP_ADD, OP_SUB,
            OP_STA, OP_JMP, OP_JZ,  OP_HLT: op_legal = op_hi_zero;
            default:                        op_legal = 1'b0;
        endcase
    end

    // The phase bus is self-redundant: both strobes and step are functions of phase.
    assign perr = (clk_s0 != (phase == 2'd1))
               || (clk_s1 != (phase == 2'd3))
               || (step   != phase[1]);

    assign launch = !perr && ((state == IDLE) || (state == HALT)) && start && (phase == 2'd0);
    assign retire = !perr && (state == EXEC) && clk_s1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (perr) begin
            state_nxt = HALT;
        end else begin
            unique case (state)
                IDLE, HALT: if (launch)  state_nxt = FETCH;
                FETCH:      if (clk_s1)  state_nxt = EXEC;
                EXEC:       if (clk_s1)  state_nxt = op_is_hlt ? HALT : FETCH;
                default:                 state_nxt = IDLE;
            endcase
        end
    end

    // Instruction counter and sticky status; a launch starts a fresh run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
            phase_err   <= 1'b0;
            illegal_op  <= 1'b0;
        end else if (perr) begin
            phase_err <= 1'b1;
        end else if (launch) begin
            instr_count <= '0;
            phase_err   <= 1'b0;
            illegal_op  <= 1'b0;
        end else if (retire) begin
            if (instr_count != '1) begin
                instr_count <= instr_count + IC_W'(1);
            end
            if (!op_legal) begin
                illegal_op <= 1'b1;
            end
        end
    end

    assign running = (state == FETCH) || (state == EXEC);
    assign halted  = (state == HALT);
    assign E       = running;

    // NOTE: every output of this block gets a default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    always_comb begin
        addr_sel = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        ir_ld    = 1'b0;
        pc_inc   = 1'b0;
        pc_ld    = 1'b0;
        acc_ld   = 1'b0;
        alu_op   = ALU_PASS;
        if (!perr) begin
            unique case (state)
                FETCH: begin
                    mem_rd = ~phase[1];
                    ir_ld  = clk_s0;
                    pc_inc = clk_s1;
                end
                EXEC: begin
                    addr_sel = 1'b1;
                    if (op_hi_zero) begin
                        case (op)
                            OP_LDA: begin
                                mem_rd = ~phase[1];
                                acc_ld = clk_s0;
                                alu_op = ALU_PASS;
                            end
                            OP_ADD: begin
                                mem_rd = ~phase[1];
                                acc_ld = clk_s0;
                                alu_op = ALU_ADD;
                            end
                            OP_SUB: begin
                                mem_rd = ~phase[1];
                                acc_ld = clk_s0;
                                alu_op = ALU_SUB;
                            end
                            OP_STA: mem_wr = step & ~clk_s1;
                            OP_JMP: pc_ld  = clk_s1;
                            OP_JZ:  pc_ld  = clk_s1 & zero;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cycle_controller.sv
// Scoreboard bench for cycle_controller: tasks queue the expected per-cycle
// output snapshot, a negedge monitor pops and compares against the DUT.
module tb_cycle_controller;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} st_e;

    typedef struct packed {
        logic [1:0]  ph;
        logic        e;
        logic        running;
        logic        halted;
        logic [8:0]  stb;   // addr_sel mem_rd mem_wr ir_ld pc_inc pc_ld acc_ld alu_op[1:0]
        logic [15:0] cnt;
        logic        perr;
        logic        ill;
    } snap_t;

    typedef struct {
        string name;
        snap_t val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  phase = 2'd0;
    logic        clk_s0;
    logic        clk_s1;
    logic        step;
    logic [3:0]  opcode;
    logic        zero;
    logic        E;
    logic        running;
    logic        halted;
    logic        addr_sel;
    logic        mem_rd;
    logic        mem_wr;
    logic        ir_ld;
    logic        pc_inc;
    logic        pc_ld;
    logic        acc_ld;
    logic [1:0]  alu_op;
    logic [15:0] instr_count;
    logic        phase_err;
    logic        illegal_op;

    logic        force_s1;
    logic        gen_set;
    logic [1:0]  gen_val;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    st_e         exp_st;
    logic [1:0]  exp_ph;
    logic [15:0] exp_cnt;
    logic        exp_perr;
    logic        exp_ill;

    cycle_controller #(.OPW(4), .IC_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .phase(phase),
        .clk_s0(clk_s0), .clk_s1(clk_s1), .step(step),
        .opcode(opcode), .zero(zero), .E(E), .running(running), .halted(halted),
        .addr_sel(addr_sel), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_ld(ir_ld),
        .pc_inc(pc_inc), .pc_ld(pc_ld), .acc_ld(acc_ld), .alu_op(alu_op),
        .instr_count(instr_count), .phase_err(phase_err), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Timing generator model: advances while E, can be preloaded to any phase.
    always @(posedge clk) begin
        if (gen_set)  phase <= gen_val;
        else if (E)   phase <= phase + 2'd1;
    end
    assign clk_s0 = (phase == 2'd1);
    assign clk_s1 = (phase == 2'd3) | force_s1;
    assign step   = phase[1];

    function automatic snap_t dut_snap();
        snap_t s;
        s.ph      = phase;
        s.e       = E;
        s.running = running;
        s.halted  = halted;
        s.stb     = {addr_sel, mem_rd, mem_wr, ir_ld, pc_inc, pc_ld, acc_ld, alu_op};
        s.cnt     = instr_count;
        s.perr    = phase_err;
        s.ill     = illegal_op;
        return s;
    endfunction

    task automatic check(input string name, input snap_t act, input snap_t want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (ph,E,run,halt,stb9,cnt16,perr,ill)", name, act, want);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t x;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check(x.name, dut_snap(), x.val);
        end
    end

    function automatic snap_t exp_snap(input logic [8:0] stb);
        snap_t s;
        logic  run;
        run       = (exp_st == S_FETCH) || (exp_st == S_EXEC);
        s.ph      = exp_ph;
        s.e       = run;
        s.running = run;
        s.halted  = (exp_st == S_HALT);
        s.stb     = stb;
        s.cnt     = exp_cnt;
        s.perr    = exp_perr;
        s.ill     = exp_ill;
        return s;
    endfunction

    task automatic step_cycle(input string name, input logic [8:0] stb);
        exp_t x;
        x.name = name;
        x.val  = exp_snap(stb);
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] fetch_tbl(input int p);
        case (p)
            0:       return 9'b0_1_0_0_0_0_0_00;
            1:       return 9'b0_1_0_1_0_0_0_00;
            3:       return 9'b0_0_0_0_1_0_0_00;
            default: return 9'b0_0_0_0_0_0_0_00;
        endcase
    endfunction

    function automatic logic [8:0] exec_tbl(input logic [3:0] op, input int p, input logic z);
        case (op)
            4'h1: return (p == 0) ? 9'b1_1_0_0_0_0_0_00 : (p == 1) ? 9'b1_1_0_0_0_0_1_00 : 9'b1_0_0_0_0_0_0_00;
            4'h2: return (p == 0) ? 9'b1_1_0_0_0_0_0_01 : (p == 1) ? 9'b1_1_0_0_0_0_1_01 : 9'b1_0_0_0_0_0_0_01;
            4'h3: return (p == 0) ? 9'b1_1_0_0_0_0_0_10 : (p == 1) ? 9'b1_1_0_0_0_0_1_10 : 9'b1_0_0_0_0_0_0_10;
            4'h4: return (p == 2) ? 9'b1_0_1_0_0_0_0_00 : 9'b1_0_0_0_0_0_0_00;
            4'h5: return (p == 3) ? 9'b1_0_0_0_0_1_0_00 : 9'b1_0_0_0_0_0_0_00;
            4'h6: return (p == 3 && z) ? 9'b1_0_0_0_0_1_0_00 : 9'b1_0_0_0_0_0_0_00;
            default: return 9'b1_0_0_0_0_0_0_00;
        endcase
    endfunction

    task automatic idle(input string name, input int n);
        for (int i = 0; i < n; i++) step_cycle(name, 9'd0);
    endtask

    // Start request at phase 0 from IDLE/HALT; the run begins with cleared status.
    task automatic begin_run(input string name);
        start = 1'b1;
        step_cycle(name, 9'd0);
        start    = 1'b0;
        exp_st   = S_FETCH;
        exp_ph   = 2'd0;
        exp_cnt  = 16'd0;
        exp_perr = 1'b0;
        exp_ill  = 1'b0;
    endtask

    task automatic fetch(input string name);
        exp_st = S_FETCH;
        for (int p = 0; p < 4; p++) begin
            exp_ph = 2'(p);
            step_cycle($sformatf("%s_f%0d", name, p), fetch_tbl(p));
        end
        exp_st = S_EXEC;
        exp_ph = 2'd0;
    endtask

    task automatic instr(input string name, input logic [3:0] op, input logic z);
        opcode = op;
        zero   = z;
        fetch(name);
        for (int p = 0; p < 4; p++) begin
            exp_ph = 2'(p);
            step_cycle($sformatf("%s_e%0d", name, p), exec_tbl(op, p, z));
        end
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        if (!(op <= 4'h6 || op == 4'hF)) exp_ill = 1'b1;
        exp_st = (op == 4'hF) ? S_HALT : S_FETCH;
        exp_ph = 2'd0;
    endtask

    task automatic load_phase(input string name, input logic [1:0] v);
        gen_val = v;
        gen_set = 1'b1;
        step_cycle(name, 9'd0);
        gen_set = 1'b0;
        exp_ph  = v;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: still running at %0t, wanted completion", $time);
        summary();
        $finish;
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        opcode   = 4'h0;
        zero     = 1'b0;
        force_s1 = 1'b0;
        gen_set  = 1'b0;
        gen_val  = 2'd0;
        exp_st   = S_IDLE;
        exp_ph   = 2'd0;
        exp_cnt  = 16'd0;
        exp_perr = 1'b0;
        exp_ill  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step_cycle("reset", 9'd0);
        rst_n = 1'b1;
        step_cycle("idle", 9'd0);

        // T1: LDA with start held high while running (ignored), then HLT
        begin_run("t1_go");
        start = 1'b1;
        instr("t1_lda", 4'h1, 1'b0);
        start = 1'b0;
        instr("t1_hlt", 4'hF, 1'b0);
        idle("t1_halt", 2);

        // T2: ADD, SUB, STA, HLT; generator must park at phase 0
        begin_run("t2_go");
        instr("t2_add", 4'h2, 1'b0);
        instr("t2_sub", 4'h3, 1'b0);
        instr("t2_sta", 4'h4, 1'b0);
        instr("t2_hlt", 4'hF, 1'b0);
        idle("t2_park", 2);

        // T3: conditional and unconditional jumps
        begin_run("t3_go");
        instr("t3_jz0", 4'h6, 1'b0);
        instr("t3_jz1", 4'h6, 1'b1);
        instr("t3_jmp", 4'h5, 1'b0);
        instr("t3_hlt", 4'hF, 1'b0);

        // T4: clk_s1 forced at EXEC phase 2 of an ADD
        begin_run("t4_go");
        instr("t4_nop", 4'h0, 1'b0);
        opcode = 4'h2;
        fetch("t4_add");
        for (int p = 0; p < 2; p++) begin
            exp_ph = 2'(p);
            step_cycle($sformatf("t4_add_e%0d", p), exec_tbl(4'h2, p, 1'b0));
        end
        exp_ph   = 2'd2;
        force_s1 = 1'b1;
        step_cycle("t4_err", 9'd0);
        force_s1 = 1'b0;
        exp_st   = S_HALT;
        exp_perr = 1'b1;
        exp_ph   = 2'd3;
        idle("t4_halt", 2);
        load_phase("t4_park", 2'd0);

        // T5: undefined opcode, then restart from HALT clears status
        begin_run("t5_go");
        instr("t5_ill", 4'h9, 1'b0);
        instr("t5_hlt", 4'hF, 1'b0);
        idle("t5_halt", 1);
        begin_run("t5_restart");
        instr("t5_hlt2", 4'hF, 1'b0);

        // T6: asynchronous reset at EXEC phase 2, then start gated by phase 0
        begin_run("t6_go");
        instr("t6_lda", 4'h1, 1'b0);
        opcode = 4'h0;
        fetch("t6_nop");
        for (int p = 0; p < 2; p++) begin
            exp_ph = 2'(p);
            step_cycle($sformatf("t6_nop_e%0d", p), exec_tbl(4'h0, p, 1'b0));
        end
        rst_n = 1'b0;
        #1;
        exp_st  = S_IDLE;
        exp_ph  = 2'd2;
        exp_cnt = 16'd0;
        check("t6_async", dut_snap(), exp_snap(9'd0));
        step_cycle("t6_rst", 9'd0);
        rst_n = 1'b1;
        load_phase("t6_load1", 2'd1);
        start = 1'b1;
        idle("t6_ph1", 2);
        load_phase("t6_load0", 2'd0);
        step_cycle("t6_launch", 9'd0);
        start  = 1'b0;
        exp_st = S_FETCH;
        instr("t6_hlt", 4'hF, 1'b0);
        idle("t6_halt", 1);

        repeat (2) @(posedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", sb_q.size());
        end
        summary();
        $finish;
    end

endmodule
